bitstream_collector: RTL and testbench
======================================

BITSTREAM_COLLECTOR -- requirements
Module: bitstream_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of word-FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data_ready  input  1  one-cycle strobe: a full 32-bit word is present on JPEG_bitstream.
REQ-005 SHALL have port JPEG_bitstream  input  32  Huffman-coded bits, MSB first, bit 31 oldest.
REQ-006 SHALL have port orc  input  5  count of valid leftover bits (0..31), meaningful only with eob_in.
REQ-007 SHALL have port eob_in  input  1  one-cycle flush strobe: orc bits, left-aligned in JPEG_bitstream[31:32-orc], are the final bits.
REQ-008 SHALL have port byte_out  output  8  stuffed output byte.
REQ-009 SHALL have port byte_valid  output  1  byte_out holds a valid byte.
REQ-010 SHALL have port byte_ready  input  1  downstream accepts byte_out when byte_valid && byte_ready.
REQ-011 SHALL have port fifo_full  output  1  all DEPTH entries occupied.
REQ-012 SHALL have port overflow  output  1  sticky: a write was dropped.

Function
REQ-013 SHALL store each accepted write as one FIFO entry: {word[31:0], nbits[5:0]}; nbits=32 for data_ready, nbits=orc for eob_in.
REQ-014 SHALL ignore eob_in when orc=0 (no entry written).
REQ-015 SHALL give eob_in priority when data_ready and eob_in coincide; the word is written once as a flush entry with nbits=orc.
REQ-016 SHALL drop a write when fifo_full=1 and no pop occurs in the same cycle, and SHALL set overflow=1 until reset.
REQ-017 SHALL accept a write when full if a pop occurs in the same cycle; the count stays at DEPTH.
REQ-018 SHALL run an output FSM with states IDLE, LOAD, EMIT, STUFF.
REQ-019 IDLE: if FIFO non-empty -> LOAD; else stay; byte_valid=0.
REQ-020 LOAD: pop the head entry into a 32-bit shift register and a 6-bit remaining-bit counter; -> EMIT.
REQ-021 EMIT: byte_out = top 8 bits of the shift register; when remaining < 8, the low (8-remaining) bits SHALL be forced to 1 (JPEG padding); byte_valid=1.
REQ-022 On EMIT handshake: shift left 8, remaining = max(remaining-8, 0); if the emitted byte was 0xFF -> STUFF; else if remaining=0 -> LOAD when FIFO non-empty, else IDLE; else stay in EMIT.
REQ-023 STUFF: byte_out=0x00, byte_valid=1; on handshake leave by the same remaining/FIFO rule as REQ-022.
REQ-024 SHALL hold byte_out and byte_valid stable while byte_valid=1 and byte_ready=0.
REQ-025 SHALL stuff padded bytes that equal 0xFF exactly as data bytes.
REQ-026 Latency: with an empty FIFO, IDLE state and byte_ready=1, byte_valid SHALL rise two rising edges after the edge that samples data_ready; it then sustains one byte per cycle with no gaps between words.
REQ-027 SHALL emit bytes of consecutive entries in write order, with no gaps and no duplicates.

Reset
REQ-028 On rst=1, the block SHALL asynchronously clear the FIFO pointers and count, the shift register and the counter, and set FSM=IDLE, byte_out=0x00, byte_valid=0, fifo_full=0, overflow=0.
REQ-029 Reset mid-emission SHALL discard all buffered and partial data; the first post-reset byte SHALL come only from a post-reset write.

Verification
REQ-030 data_ready with 0x12345678, byte_ready=1 -> bytes 0x12,0x34,0x56,0x78 on consecutive cycles, first at the 2nd edge after sampling.
REQ-031 data_ready with 0xFF00FFAB -> bytes 0xFF,0x00,0x00,0xFF,0x00,0xAB.
REQ-032 eob_in, orc=12, word 0xABC00000 -> bytes 0xAB,0xCF; eob_in, orc=9, word 0xFF800000 -> 0xFF,0x00,0xFF,0x00.
REQ-033 byte_ready=0, then 5 data_ready writes with DEPTH=4 -> fifo_full=1 after the 4th write, overflow=1 after the 5th; with byte_ready=1, the first 4 words drain intact.
REQ-034 rst pulse after 2 of 4 bytes of a word -> byte_valid=0 immediately; next word 0x01020304 -> only 0x01,0x02,0x03,0x04 are emitted.
REQ-035 data_ready and eob_in together, orc=8, word 0x5A000000 -> single byte 0x5A.

Source files
------------

// File: rtl/bitstream_collector_if.sv
// Handshake bundle between a Huffman word source / byte sink and the bitstream collector.
// The master side drives words and accepts bytes; the slave side is the collector.
interface bitstream_collector_if;
  logic        data_ready;
  logic [31:0] JPEG_bitstream;
  logic [4:0]  orc;
  logic        eob_in;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        fifo_full;
  logic        overflow;

  modport master (
    output data_ready, JPEG_bitstream, orc, eob_in, byte_ready,
    input  byte_out, byte_valid, fifo_full, overflow
  );

  modport slave (
    input  data_ready, JPEG_bitstream, orc, eob_in, byte_ready,
    output byte_out, byte_valid, fifo_full, overflow
  );
endinterface

// File: rtl/bitstream_collector.sv
// Buffers 32-bit Huffman words in a small FIFO and emits them MSB-first as bytes,
// padding short flush words with 1s and inserting 0x00 after every 0xFF byte.
module bitstream_collector #(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  bitstream_collector_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, STUFF} state_t;

  logic [31:0]   mem_word  [DEPTH];
  logic [5:0]    mem_nbits [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t      state;
  logic [31:0] shift_reg;
  logic [5:0]  remaining;
  logic [7:0]  byte_q;
  logic        valid_q;
  logic        overflow_q;

  logic        empty;
  logic        full;
  logic        wr_req;
  logic        wr_en;
  logic [5:0]  wr_nbits;
  logic        handshake;
  logic        entry_done;
  logic        pop;
  logic [31:0] head_word;
  logic [5:0]  head_nbits;
  logic [31:0] shifted;
  logic [5:0]  rem_next;

  // Top byte of the shift register; bits past the end of the entry become 1s.
  function automatic logic [7:0] pad_byte(input logic [31:0] sr, input logic [5:0] rem);
    if (rem < 6'd8) begin
      return sr[31:24] | (8'hFF >> rem[2:0]);
    end
    return sr[31:24];
  endfunction

  always_comb begin
    empty      = (count == '0);
    full       = (count == (AW+1)'(DEPTH));
    wr_req     = bus.eob_in ? (bus.orc != 5'd0) : bus.data_ready;
    wr_nbits   = bus.eob_in ? {1'b0, bus.orc} : 6'd32;
    handshake  = valid_q && bus.byte_ready;
    shifted    = shift_reg << 8;
    rem_next   = (remaining > 6'd8) ? (remaining - 6'd8) : 6'd0;
    head_word  = mem_word[rd_ptr];
    head_nbits = mem_nbits[rd_ptr];
    // The next entry is fetched on the same handshake that finishes the current one,
    // so consecutive words stream out without a bubble.
    entry_done = handshake &&
                 (((state == EMIT) && (byte_q != 8'hFF) && (rem_next == 6'd0)) ||
                  ((state == STUFF) && (remaining == 6'd0)));
    pop        = (state == LOAD) || (entry_done && !empty);
    wr_en      = wr_req && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_word[wr_ptr]  <= bus.JPEG_bitstream;
      mem_nbits[wr_ptr] <= wr_nbits;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && !wr_en) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      remaining <= '0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) state <= LOAD;
        end
        LOAD: begin
          shift_reg <= head_word;
          remaining <= head_nbits;
          byte_q    <= pad_byte(head_word, head_nbits);
          valid_q   <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (handshake) begin
            shift_reg <= shifted;
            remaining <= rem_next;
            if (byte_q == 8'hFF) begin
              byte_q <= 8'h00;
              state  <= STUFF;
            end else if (rem_next != 6'd0) begin
              byte_q <= pad_byte(shifted, rem_next);
            end else if (!empty) begin
              shift_reg <= head_word;
              remaining <= head_nbits;
              byte_q    <= pad_byte(head_word, head_nbits);
            end else begin
              byte_q  <= 8'h00;
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        STUFF: begin
          if (handshake) begin
            state <= EMIT;
            if (remaining != 6'd0) begin
              byte_q <= pad_byte(shift_reg, remaining);
            end else if (!empty) begin
              shift_reg <= head_word;
              remaining <= head_nbits;
              byte_q    <= pad_byte(head_word, head_nbits);
            end else begin
              byte_q  <= 8'h00;
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign bus.fifo_full  = full;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_bitstream_collector.sv
// Scenario bench for bitstream_collector: directed cases plus a randomized run,
// all checked against a byte-level model of padding and 0xFF stuffing.
module tb_bitstream_collector;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  bitstream_collector_if bus();

  bitstream_collector #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every byte that will be taken at the next rising edge is captured here.
  always @(negedge clk) begin
    if (!rst && bus.byte_valid && bus.byte_ready) begin
      obs_q.push_back(bus.byte_out);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic dr, input logic eob, input logic [31:0] w, input logic [4:0] o);
    bus.data_ready     = dr;
    bus.eob_in         = eob;
    bus.JPEG_bitstream = w;
    bus.orc            = o;
    tick();
    bus.data_ready = 1'b0;
    bus.eob_in     = 1'b0;
  endtask

  // Expected byte stream of one entry: nbits bits MSB first, last byte 1-padded, 0x00 after 0xFF.
  function automatic void model_entry(input logic [31:0] w, input int nbits);
    int          left;
    logic [31:0] s;
    logic [7:0]  b;
    left = nbits;
    s    = w;
    while (left > 0) begin
      b = s[31:24];
      for (int k = 0; k < 8 - left; k++) b[k] = 1'b1;
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
      s    = s << 8;
      left = left - 8;
    end
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic drain(input int budget, output bit ok);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    ok = (obs_q.size() >= exp_q.size());
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.byte_valid); end
    total++; if (bus.byte_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_byte got=%h want=00", bus.byte_out); end
    total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", bus.fifo_full); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", bus.overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int c0;
    clear_queues();
    bus.byte_ready = 1'b1;
    put(1'b1, 1'b0, 32'h12345678, 5'd0);
    c0 = cyc;
    model_entry(32'h12345678, 32);
    drain(40, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL basic_timeout got=%0d want=%0d bytes", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL basic_byte[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
      total++; if (obs_cyc[i] != c0 + 2 + i) begin bad++; $display("[TB] FAIL basic_timing[%0d] got=%0d want=%0d", i, obs_cyc[i] - c0, 2 + i); end
    end
  endtask

  task automatic test_stuffing();
    bit ok;
    int c0;
    clear_queues();
    bus.byte_ready = 1'b1;
    put(1'b1, 1'b0, 32'hFF00FFAB, 5'd0);
    c0 = cyc;
    model_entry(32'hFF00FFAB, 32);
    drain(40, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL stuff_timeout got=%0d want=%0d bytes", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != 6) begin bad++; $display("[TB] FAIL stuff_count got=%0d want=6", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL stuff_byte[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
      total++; if (obs_cyc[i] != c0 + 2 + i) begin bad++; $display("[TB] FAIL stuff_timing[%0d] got=%0d want=%0d", i, obs_cyc[i] - c0, 2 + i); end
    end
  endtask

  task automatic test_eob();
    bit ok;
    clear_queues();
    bus.byte_ready = 1'b1;
    put(1'b0, 1'b1, 32'hABC00000, 5'd12);
    model_entry(32'hABC00000, 12);
    put(1'b0, 1'b1, 32'hDEADBEEF, 5'd0);
    put(1'b0, 1'b1, 32'hFF800000, 5'd9);
    model_entry(32'hFF800000, 9);
    put(1'b1, 1'b1, 32'h5A000000, 5'd8);
    model_entry(32'h5A000000, 8);
    drain(60, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL eob_timeout got=%0d want=%0d bytes", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != 7) begin bad++; $display("[TB] FAIL eob_count got=%0d want=7", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL eob_byte[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit          ok;
    int          n;
    logic [31:0] words [5];
    logic [7:0]  held;
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEF001, 32'h0BADBEEF};
    clear_queues();
    bus.byte_ready = 1'b0;
    put(1'b1, 1'b0, 32'hC0FFEE00, 5'd0);
    model_entry(32'hC0FFEE00, 32);
    n = 0;
    while (!bus.byte_valid && n < 10) begin tick(); n++; end
    total++; if (bus.byte_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovf_blocker_valid got=%b want=1", bus.byte_valid); end
    held = bus.byte_out;
    for (int k = 0; k < 5; k++) begin
      put(1'b1, 1'b0, words[k], 5'd0);
      if (k < 4) model_entry(words[k], 32);
      total++; if (bus.fifo_full !== (k >= 3)) begin bad++; $display("[TB] FAIL ovf_full[%0d] got=%b want=%b", k, bus.fifo_full, k >= 3); end
      total++; if (bus.overflow !== (k == 4)) begin bad++; $display("[TB] FAIL ovf_sticky[%0d] got=%b want=%b", k, bus.overflow, k == 4); end
      total++; if (bus.byte_out !== held || bus.byte_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovf_hold[%0d] got=%h/%b want=%h/1", k, bus.byte_out, bus.byte_valid, held); end
    end
    bus.byte_ready = 1'b1;
    drain(100, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL ovf_timeout got=%0d want=%0d bytes", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL ovf_byte[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_after_drain got=%b want=1", bus.overflow); end
    total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("[TB] FAIL ovf_full_after_drain got=%b want=0", bus.fifo_full); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clear_queues();
    bus.byte_ready = 1'b1;
    put(1'b1, 1'b0, 32'hA1B2C3D4, 5'd0);
    put(1'b1, 1'b0, 32'hE5F60718, 5'd0);
    n = 0;
    while (obs_q.size() < 2 && n < 20) begin tick(); n++; end
    total++; if (obs_q.size() < 2) begin bad++; $display("[TB] FAIL rstmid_start got=%0d want=2 bytes", obs_q.size()); end
    rst = 1'b1;
    #1;
    total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b want=0", bus.byte_valid); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_overflow got=%b want=0", bus.overflow); end
    tick();
    rst = 1'b0;
    tick();
    clear_queues();
    put(1'b1, 1'b0, 32'h01020304, 5'd0);
    model_entry(32'h01020304, 32);
    drain(40, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rstmid_timeout got=%0d want=%0d bytes", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != 4) begin bad++; $display("[TB] FAIL rstmid_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rstmid_byte[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit          ok;
    int          writes;
    int          kind;
    int          nb;
    logic [31:0] w;
    logic [4:0]  o;
    clear_queues();
    writes = 0;
    for (int n = 0; n < 3000 && writes < 40; n++) begin
      bus.byte_ready = ($urandom_range(0, 3) != 0);
      if (!bus.fifo_full && $urandom_range(0, 1) == 1) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) w[b*8 +: 8] = 8'hFF;
        kind = $urandom_range(0, 2);
        o    = 5'($urandom_range(1, 31));
        bus.data_ready     = (kind != 1);
        bus.eob_in         = (kind != 0);
        bus.JPEG_bitstream = w;
        bus.orc            = o;
        nb = (kind == 0) ? 32 : int'(o);
        model_entry(w, nb);
        writes++;
      end
      tick();
      bus.data_ready = 1'b0;
      bus.eob_in     = 1'b0;
    end
    bus.byte_ready = 1'b1;
    drain(1500, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rand_timeout got=%0d want=%0d bytes", obs_q.size(), exp_q.size()); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rand_byte[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL rand_overflow got=%b want=0", bus.overflow); end
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    cyc                = 0;
    rst                = 1'b1;
    bus.data_ready     = 1'b0;
    bus.eob_in         = 1'b0;
    bus.JPEG_bitstream = '0;
    bus.orc            = '0;
    bus.byte_ready     = 1'b0;
    test_reset();
    test_basic();
    test_stuffing();
    test_eob();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
